// File: rtl/bram_pattern_checker.sv
// BRAM bring-up engine: fills every word of a single-port BRAM with a
// selectable pattern, reads it back through an RD_LAT-deep compare pipeline
// and reports pass/fail, a saturating error count and the first bad address.
module bram_pattern_checker #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 11,
   parameter int RD_LAT      = 1,
   parameter int AUTO_PERIOD = 50_000_000,
   parameter int ERR_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] seed,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [15:0]       run_count
);

   typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ERR_W-1:0]  ERR_MAX   = '1;
   localparam logic [31:0]       AUTO_LAST = 32'(AUTO_PERIOD - 1);
   localparam logic [1:0]        DRAIN_END = 2'(RD_LAT - 1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [1:0]          drain_cnt, drain_nxt;
   logic [1:0]          mode_q, mode_sel;
   logic [DATA_W-1:0]   seed_q, seed_sel;
   logic [31:0]         auto_cnt;
   logic                auto_tick, trig;
   logic                mism;
   logic [ERR_W-1:0]    err_nxt;

   // compare pipeline: stage RD_LAT lines up with bram_rdata
   logic [RD_LAT:1]     vld_pipe;
   logic [DATA_W-1:0]   exp_pipe [1:RD_LAT];
   logic [ADDR_W-1:0]   adr_pipe [1:RD_LAT];

   // expected word for address a under pattern m / seed s
   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0] m,
                                                 input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] v;
      v = '0;
      case (m)
         2'd0:    v = s + DATA_W'(a);
         2'd1:    v = DATA_W'(a);
         2'd2:    v = ~DATA_W'(a);
         default: for (int i = 0; i < DATA_W; i++) v[i] = (i % 2 == 0) ^ a[0];
      endcase
      return v;
   endfunction

   assign auto_tick = (AUTO_PERIOD != 0) && (auto_cnt == AUTO_LAST);
   assign trig      = (start || auto_tick) && (state == IDLE);
   assign mode_sel  = trig ? mode : mode_q;
   assign seed_sel  = trig ? seed : seed_q;

   // free-running auto-trigger counter, wraps in every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              auto_cnt <= '0;
      else if (AUTO_PERIOD == 0 || auto_tick) auto_cnt <= '0;
      else                                   auto_cnt <= auto_cnt + 32'd1;
   end

   // next state / next address; bram_addr doubles as the sweep address
   always_comb begin
      state_nxt = state;
      addr_nxt  = bram_addr;
      drain_nxt = drain_cnt;
      case (state)
         IDLE: if (trig) begin
            state_nxt = WR;
            addr_nxt  = '0;
         end
         WR: begin
            addr_nxt = bram_addr + ADDR_W'(1);
            if (bram_addr == LAST_ADDR) state_nxt = RD;
         end
         RD: begin
            addr_nxt = bram_addr + ADDR_W'(1);
            if (bram_addr == LAST_ADDR) begin
               state_nxt = DRAIN;
               drain_nxt = '0;
            end
         end
         DRAIN: begin
            drain_nxt = drain_cnt + 2'd1;
            if (drain_cnt == DRAIN_END) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state and registered BRAM/status outputs, all derived from next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         drain_cnt  <= '0;
         mode_q     <= '0;
         seed_q     <= '0;
         bram_en    <= 1'b0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         drain_cnt  <= drain_nxt;
         mode_q     <= mode_sel;
         seed_q     <= seed_sel;
         bram_en    <= (state_nxt == WR) || (state_nxt == RD);
         bram_we    <= (state_nxt == WR);
         bram_addr  <= ((state_nxt == WR) || (state_nxt == RD)) ? addr_nxt : '0;
         bram_wdata <= (state_nxt == WR) ? pattern(addr_nxt, mode_sel, seed_sel) : '0;
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == DONE);
      end
   end

   // expected data / address ride alongside the BRAM read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         for (int i = 1; i <= RD_LAT; i++) begin
            exp_pipe[i] <= '0;
            adr_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[1] <= (state == RD);
         exp_pipe[1] <= pattern(bram_addr, mode_q, seed_q);
         adr_pipe[1] <= bram_addr;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            exp_pipe[i] <= exp_pipe[i-1];
            adr_pipe[i] <= adr_pipe[i-1];
         end
      end
   end

   // mismatch detect and saturating error count
   always_comb begin
      mism    = vld_pipe[RD_LAT] && (bram_rdata != exp_pipe[RD_LAT]);
      err_nxt = err_count;
      if (mism && err_count != ERR_MAX) err_nxt = err_count + ERR_W'(1);
   end

   // run results; pass is settled on entry to DONE so it is valid with done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count      <= '0;
         first_err_addr <= '0;
         pass           <= 1'b0;
         run_count      <= '0;
      end else if (trig) begin
         err_count      <= '0;
         first_err_addr <= '0;
         pass           <= 1'b0;
      end else begin
         err_count <= err_nxt;
         if (mism && err_count == '0) first_err_addr <= adr_pipe[RD_LAT];
         if (state == DRAIN && state_nxt == DONE) begin
            pass      <= (err_nxt == '0);
            run_count <= run_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_bram_pattern_checker.sv
// Scoreboard bench: instance A (RD_LAT=1, ERR_W=2, no auto) runs directed
// start-triggered vectors; instance B (RD_LAT=3, AUTO_PERIOD=100) sweeps all
// modes off the auto trigger. Expected results are queued at stimulus time
// and popped by per-instance monitors on each done pulse.
module tb_bram_pattern_checker;

   typedef struct {
      logic pass;
      int   err;
      int   ferr;
      int   runs;
      int   cyc;
      int   busy;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   exp_t qa[$];
   exp_t qb[$];

   // ---------------- instance A ----------------
   logic        rst_a, start_a;
   logic [1:0]  mode_a;
   logic [15:0] seed_a, wdata_a, rdata_a;
   logic        en_a, we_a, busy_a, done_a, pass_a;
   logic [3:0]  addr_a, ferr_a;
   logic [1:0]  err_a;
   logic [15:0] runs_a;
   logic        fault_a, zero_a;
   logic [15:0] mem_a [16];
   int          cyc_a;

   bram_pattern_checker #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .AUTO_PERIOD(0), .ERR_W(2)) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .mode(mode_a), .seed(seed_a),
      .bram_en(en_a), .bram_we(we_a), .bram_addr(addr_a), .bram_wdata(wdata_a),
      .bram_rdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_err_addr(ferr_a), .run_count(runs_a));

   // A's BRAM: 1-cycle read, optional bit-3 flip at addresses 5/9 or all-zero reads
   always @(posedge clk) begin
      if (en_a && we_a) mem_a[addr_a] <= wdata_a;
      if (en_a && !we_a)
         rdata_a <= zero_a ? 16'h0000 :
                    mem_a[addr_a] ^ ((fault_a && (addr_a == 4'd5 || addr_a == 4'd9)) ? 16'h0008 : 16'h0000);
   end

   always @(posedge clk or negedge rst_a)
      if (!rst_a) cyc_a <= 0; else cyc_a <= cyc_a + 1;

   // ---------------- instance B ----------------
   logic        rst_b, start_b;
   logic [1:0]  mode_b;
   logic [15:0] seed_b, wdata_b, rdata_b;
   logic        en_b, we_b, busy_b, done_b, pass_b;
   logic [3:0]  addr_b, ferr_b;
   logic [15:0] err_b;
   logic [15:0] runs_b;
   logic [15:0] mem_b [16];
   logic [15:0] bp0, bp1, bp2;
   int          cyc_b;

   bram_pattern_checker #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3), .AUTO_PERIOD(100), .ERR_W(16)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .mode(mode_b), .seed(seed_b),
      .bram_en(en_b), .bram_we(we_b), .bram_addr(addr_b), .bram_wdata(wdata_b),
      .bram_rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_err_addr(ferr_b), .run_count(runs_b));

   // B's BRAM: ideal, 3-cycle read latency
   always @(posedge clk) begin
      if (en_b && we_b) mem_b[addr_b] <= wdata_b;
      bp0 <= mem_b[addr_b];
      bp1 <= bp0;
      bp2 <= bp1;
   end
   assign rdata_b = bp2;

   always @(posedge clk or negedge rst_b)
      if (!rst_b) cyc_b <= 0; else cyc_b <= cyc_b + 1;

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   // monitor A: pop one expectation per done pulse
   initial begin
      exp_t e;
      int   bc;
      bc = 0;
      forever begin
         @(negedge clk);
         if (!rst_a) bc = 0;
         else begin
            if (busy_a) bc++;
            if (done_a) begin
               chk("a_done_expected", 32'(qa.size() != 0), 1);
               if (qa.size() != 0) begin
                  e = qa.pop_front();
                  chk("a_pass",      32'(pass_a), 32'(e.pass));
                  chk("a_err_count", 32'(err_a),  32'(e.err));
                  chk("a_first_err", 32'(ferr_a), 32'(e.ferr));
                  chk("a_run_count", 32'(runs_a), 32'(e.runs));
                  chk("a_done_cycle", 32'(cyc_a), 32'(e.cyc));
                  chk("a_busy_span", 32'(bc),     32'(e.busy));
               end
               bc = 0;
            end
         end
      end
   end

   // monitor B
   initial begin
      exp_t e;
      int   bc;
      bc = 0;
      forever begin
         @(negedge clk);
         if (!rst_b) bc = 0;
         else begin
            if (busy_b) bc++;
            if (done_b) begin
               chk("b_done_expected", 32'(qb.size() != 0), 1);
               if (qb.size() != 0) begin
                  e = qb.pop_front();
                  chk("b_pass",      32'(pass_b), 32'(e.pass));
                  chk("b_err_count", 32'(err_b),  32'(e.err));
                  chk("b_first_err", 32'(ferr_b), 32'(e.ferr));
                  chk("b_run_count", 32'(runs_b), 32'(e.runs));
                  chk("b_done_cycle", 32'(cyc_b), 32'(e.cyc));
                  chk("b_busy_span", 32'(bc),     32'(e.busy));
               end
               bc = 0;
            end
         end
      end
   end

   // one start-triggered run on A; called at a negedge, trigger cycle T = cyc_a now
   task automatic run_a(input logic [1:0] m, input logic [15:0] s, input logic ep,
                        input int ee, input int ef, input int er,
                        input bit glitch, input bit poke);
      exp_t e;
      bit   got;
      mode_a  = m;
      seed_a  = s;
      start_a = 1'b1;
      e.pass = ep; e.err = ee; e.ferr = ef; e.runs = er;
      e.cyc  = cyc_a + 34;   // T + 2*16 + RD_LAT + 1
      e.busy = 34;
      qa.push_back(e);
      got = 1'b0;
      for (int i = 1; i <= 100 && !got; i++) begin
         @(negedge clk);
         start_a = glitch && (i == 5 || i == 20);
         if (done_a) got = 1'b1;
      end
      chk("a_done_seen", 32'(got), 1);
      if (poke) begin
         start_a = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
         chk("a_start_in_done_ignored", 32'(busy_a), 0);
      end
      start_a = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit got;
      rst_a = 1'b0; start_a = 1'b0; mode_a = 2'd0; seed_a = '0; fault_a = 1'b0; zero_a = 1'b0;
      rst_b = 1'b0; start_b = 1'b0; mode_b = 2'd0; seed_b = 16'h1234;
      repeat (3) @(negedge clk);

      // reset state
      chk("a_rst_bram_en",  32'(en_a), 0);
      chk("a_rst_bram_we",  32'(we_a), 0);
      chk("a_rst_addr",     32'(addr_a), 0);
      chk("a_rst_wdata",    32'(wdata_a), 0);
      chk("a_rst_busy",     32'(busy_a), 0);
      chk("a_rst_done",     32'(done_a), 0);
      chk("a_rst_pass",     32'(pass_a), 0);
      chk("a_rst_err",      32'(err_a), 0);
      chk("a_rst_ferr",     32'(ferr_a), 0);
      chk("a_rst_runs",     32'(runs_a), 0);

      rst_a = 1'b1;
      while (cyc_a != 10) @(negedge clk);

      // mode 1, start at cycle 10 -> done at 44
      run_a(2'd1, 16'h0000, 1'b1, 0, 0, 1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) chk($sformatf("a_mem_mode1[%0d]", i), 32'(mem_a[i]), 32'(i));

      // mode 0, seed 0xFFFE wraps through zero
      run_a(2'd0, 16'hFFFE, 1'b1, 0, 0, 2, 1'b0, 1'b0);
      chk("a_mem_mode0[0]",  32'(mem_a[0]),  32'h0000_FFFE);
      chk("a_mem_mode0[1]",  32'(mem_a[1]),  32'h0000_FFFF);
      chk("a_mem_mode0[2]",  32'(mem_a[2]),  32'h0000_0000);
      chk("a_mem_mode0[15]", 32'(mem_a[15]), 32'h0000_000D);

      // mode 3 with bit-3 faults at addresses 5 and 9
      fault_a = 1'b1;
      run_a(2'd3, 16'h0000, 1'b0, 2, 5, 3, 1'b0, 1'b0);
      fault_a = 1'b0;
      chk("a_mem_mode3[4]", 32'(mem_a[4]), 32'h0000_5555);
      chk("a_mem_mode3[5]", 32'(mem_a[5]), 32'h0000_AAAA);

      // all-zero reads in mode 2 saturate the 2-bit counter at 3
      zero_a = 1'b1;
      run_a(2'd2, 16'h0000, 1'b0, 3, 0, 4, 1'b0, 1'b0);
      zero_a = 1'b0;
      chk("a_mem_mode2[0]", 32'(mem_a[0]), 32'h0000_FFFF);

      // start pulses in WR, RD and DONE are ignored
      run_a(2'd1, 16'h0000, 1'b1, 0, 0, 5, 1'b1, 1'b1);

      // reset in the middle of RD
      mode_a = 2'd1; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (19) @(negedge clk);
      chk("a_busy_before_rst", 32'(busy_a), 1);
      chk("a_rd_before_rst",   32'(we_a), 0);
      rst_a = 1'b0;
      #1;
      chk("a_midrst_bram_en", 32'(en_a), 0);
      chk("a_midrst_addr",    32'(addr_a), 0);
      chk("a_midrst_busy",    32'(busy_a), 0);
      chk("a_midrst_runs",    32'(runs_a), 0);
      chk("a_midrst_pass",    32'(pass_a), 0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      run_a(2'd1, 16'h0000, 1'b1, 0, 0, 1, 1'b0, 1'b0);

      // B: auto-triggered sweep of modes 0..3, trigger at cycles 99+100k
      for (int k = 0; k < 4; k++) begin
         exp_t e;
         e.pass = 1'b1; e.err = 0; e.ferr = 0; e.runs = k + 1;
         e.cyc  = 99 + 100 * k + 36;   // T + 2*16 + 4
         e.busy = 36;
         qb.push_back(e);
      end
      rst_b = 1'b1;
      repeat (50) @(negedge clk);
      chk("b_pass_before_first_run", 32'(pass_b), 0);
      chk("b_idle_busy",             32'(busy_b), 0);
      for (int k = 0; k < 4; k++) begin
         mode_b = 2'(k);
         got = 1'b0;
         for (int i = 0; i < 150 && !got; i++) begin
            @(negedge clk);
            if (done_b) got = 1'b1;
         end
         chk($sformatf("b_done_seen_%0d", k), 32'(got), 1);
      end
      repeat (2) @(negedge clk);

      chk("a_queue_drained", 32'(qa.size()), 0);
      chk("b_queue_drained", 32'(qb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bram_pattern_checker.md
# bram_pattern_checker

Parametrised BRAM write/read/verify engine for on-chip block RAM bring-up on the Zynq PL. On each trigger it fills all `DEPTH` words of a single-port BRAM with a selectable data pattern, reads them back, and compares each word against the expected value. It reports pass/fail, a saturating error count and the first failing address. It sits between a BRAM port (native Xilinx BRAM interface) and a status/ILA probe or AXI-lite register block.

## Interface
- `DATA_W`, 16: data width of the BRAM word.
- `ADDR_W`, 11: address width; `DEPTH = 2**ADDR_W` words are tested.
- `RD_LAT`, 1: BRAM read latency in cycles, 1..3.
- `AUTO_PERIOD`, 50_000_000: auto-trigger period in clk cycles; 0 disables auto-trigger.
- `ERR_W`, 16: width of the error counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle trigger request.
- `mode`  in  2  pattern select, sampled at trigger.
- `seed`  in  DATA_W  counter-pattern start value, sampled at trigger.
- `bram_en`  out  1  BRAM port enable.
- `bram_we`  out  1  BRAM write enable.
- `bram_addr`  out  ADDR_W  BRAM address.
- `bram_wdata`  out  DATA_W  BRAM write data.
- `bram_rdata`  in  DATA_W  BRAM read data, valid `RD_LAT` cycles after a read address.
- `busy`  out  1  high from the first WR cycle through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  last completed run had zero errors; low until the first run completes.
- `err_count`  out  ERR_W  mismatches in the current/last run, saturating.
- `first_err_addr`  out  ADDR_W  address of the first mismatch in the current/last run.
- `run_count`  out  16  completed runs, wraps.

## Operation
- States: IDLE, WR, RD, DRAIN, DONE.
- Trigger: `start`=1, or the auto counter reaching `AUTO_PERIOD-1`. The auto counter free-runs 0..`AUTO_PERIOD-1` and wraps in every state.
- A trigger outside IDLE is ignored.
- At trigger: latch `mode`/`seed`; clear `err_count`, `first_err_addr`, and `pass`; set addr=0; go to WR.
- Pattern `P(a)` for address a:
  - mode 0: `seed + a`, truncated to DATA_W.
  - mode 1: a, zero-extended or truncated.
  - mode 2: bitwise NOT of the mode-1 value.
  - mode 3: all-`5` nibbles (`0x5555…`) when a is even, all-`A` nibbles when a is odd.
- WR: `bram_en=1`, `bram_we=1`, `bram_addr=a`, `bram_wdata=P(a)`. The address increments each cycle. After a=DEPTH-1, go to RD with a=0.
- RD: `bram_en=1`, `bram_we=0`, `bram_addr=a`. `P(a)` and a valid flag enter an `RD_LAT`-deep shift pipeline. After a=DEPTH-1, go to DRAIN.
- DRAIN: `bram_en=0`. Holds `RD_LAT` cycles so the last compare completes, then goes to DONE.
- Compare: each cycle the pipeline output is valid, compare `bram_rdata` to the expected value.
  - On mismatch: `err_count` increments, saturating at `2**ERR_W-1`.
  - If `err_count` was 0 before this mismatch, `first_err_addr` takes the piped address.
- DONE: for one cycle, `done=1` and `run_count` increments. `pass` is registered as `(err_count==0)` and held until the next trigger. Then go to IDLE.
- IDLE: `bram_en=0`, `bram_we=0`; `bram_addr` and `bram_wdata` are 0.
- Reset, async at any time including mid-run: state IDLE, all outputs 0, auto counter 0, pipeline flushed. No partial run resumes.

## Timing
- Trigger seen in cycle T: WR occupies T+1..T+DEPTH.
- RD occupies T+DEPTH+1..T+2·DEPTH.
- DRAIN occupies the next `RD_LAT` cycles.
- DONE, with `done=1`, is at cycle T+2·DEPTH+RD_LAT+1.
- `busy` is high over exactly that WR..DONE span.
- All outputs are registered; BRAM address and control change only on clk rising edges.
- A `start` coincident with the auto tick counts as one trigger.
- A `start` in the DONE cycle is ignored; a trigger is accepted from the next IDLE cycle.

## Test plan
- Mode 1, ADDR_W=4, RD_LAT=1, ideal BRAM model, `start` at cycle 10:
  - WR cycles 11..26 write 0..15; RD cycles 27..42; DRAIN at 43; `done` at 44.
  - `pass=1`, `err_count=0`, `run_count=1`.
- Mode 0, seed=0xFFFE, DATA_W=16, ideal BRAM: writes wrap 0xFFFE, 0xFFFF, 0x0000…; result is `pass=1`.
- Fault: model forces bit 3 of the read data at addresses 5 and 9 in mode 3 → `err_count=2`, `first_err_addr=5`, `pass=0`.
- Model returns 0 everywhere with ERR_W=2, mode 2 → `err_count` saturates at 3.
- RD_LAT=3 sweep of modes 0..3 with an ideal model: every run passes, `done` at T+2·DEPTH+4.
- Protocol:
  - `start` pulses during WR and RD are ignored (`run_count` increments once).
  - With AUTO_PERIOD=100, runs start at cycles 100 and 200.
  - `rst` low mid-RD returns everything to 0; the next `start` completes a clean run.
